// File: rtl/pixel_packer.sv
// pixel_packer: packs multi-channel pixels into SRAM_WIDTH-bit line-buffer words with a per-slot valid mask.
// Optional macro PIXEL_PACK_CHKSUM_EN adds line_chksum_o, the XOR of every word written this line.
module pixel_packer #(
  parameter int SRAM_WIDTH = 256,
  parameter int CHAN_W     = 8,
  parameter int NUM_CHAN   = 3,
  parameter int SLOT_CHAN  = 4,
  parameter int ADDR_W     = 9,
  parameter int CNT_W      = 12
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     pixel_trigger_i,
  input  logic [CNT_W-1:0]                         image_width_i,
  input  logic [ADDR_W-1:0]                        start_addr_i,
  input  logic [NUM_CHAN*CHAN_W-1:0]               pixel_data_i,
  input  logic                                     pixel_valid_i,
  output logic                                     pixel_ready_o,
  output logic                                     mem_wr_o,
  input  logic                                     mem_ready_i,
  output logic [ADDR_W-1:0]                        mem_addr_o,
  output logic [SRAM_WIDTH-1:0]                    mem_data_o,
  output logic [SRAM_WIDTH/(SLOT_CHAN*CHAN_W)-1:0] mem_mask_o,
  output logic                                     pixel_trigger_done_o,
  output logic [ADDR_W-1:0]                        word_cnt_o
`ifdef PIXEL_PACK_CHKSUM_EN
  ,
  output logic [SRAM_WIDTH-1:0]                    line_chksum_o
`endif
);

  localparam int SLOT_W  = SLOT_CHAN * CHAN_W;
  localparam int SPW     = SRAM_WIDTH / SLOT_W;
  localparam int SLOT_IW = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [SLOT_IW-1:0] LAST_SLOT = SLOT_IW'(SPW - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     width_q;
  logic [CNT_W-1:0]     pix_cnt;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W-1:0]    word_idx;
  logic [SRAM_WIDTH-1:0] acc_data, acc_data_next;
  logic [SPW-1:0]       acc_mask, acc_mask_next;
  logic [SLOT_IW-1:0]   slot_idx;
  logic                 last_pix, word_done, out_free, accept, abort, xfer;

  assign last_pix  = (pix_cnt + CNT_W'(1)) == width_q;
  assign word_done = (slot_idx == LAST_SLOT) || last_pix;
  assign out_free  = !mem_wr_o || mem_ready_i;
  // A pixel that closes a word may only enter when the output register can take that word.
  assign pixel_ready_o = (state == RUN) && (!word_done || out_free);
  assign accept    = pixel_valid_i && pixel_ready_o;
  assign abort     = ((state == RUN) || (state == DRAIN)) && !pixel_trigger_i;
  assign xfer      = mem_wr_o && mem_ready_i && !abort;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_data_next = acc_data;
    acc_mask_next = acc_mask;
    acc_data_next[slot_idx*SLOT_W +: SLOT_W] = SLOT_W'(pixel_data_i);
    acc_mask_next[slot_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      width_q              <= '0;
      pix_cnt              <= '0;
      base_addr            <= '0;
      word_idx             <= '0;
      acc_data             <= '0;
      acc_mask             <= '0;
      slot_idx             <= '0;
      mem_wr_o             <= 1'b0;
      mem_addr_o           <= '0;
      mem_data_o           <= '0;
      mem_mask_o           <= '0;
      pixel_trigger_done_o <= 1'b0;
      word_cnt_o           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pixel_trigger_i) begin
            width_q    <= image_width_i;
            base_addr  <= start_addr_i;
            pix_cnt    <= '0;
            word_idx   <= '0;
            word_cnt_o <= '0;
            acc_data   <= '0;
            acc_mask   <= '0;
            slot_idx   <= '0;
            if (image_width_i != '0) begin
              state <= RUN;
            end else begin
              state                <= DONE;
              pixel_trigger_done_o <= 1'b1;
            end
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            word_idx   <= '0;
            word_cnt_o <= '0;
            acc_data   <= '0;
            acc_mask   <= '0;
            slot_idx   <= '0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_mask_o <= '0;
          end else begin
            if (xfer) begin
              mem_wr_o   <= 1'b0;
              word_cnt_o <= word_cnt_o + ADDR_W'(1);
            end
            if (accept) begin
              pix_cnt <= pix_cnt + CNT_W'(1);
              if (word_done) begin
                mem_wr_o   <= 1'b1;
                mem_addr_o <= base_addr + word_idx;
                mem_data_o <= acc_data_next;
                mem_mask_o <= acc_mask_next;
                word_idx   <= word_idx + ADDR_W'(1);
                acc_data   <= '0;
                acc_mask   <= '0;
                slot_idx   <= '0;
                if (last_pix) state <= DRAIN;
              end else begin
                acc_data <= acc_data_next;
                acc_mask <= acc_mask_next;
                slot_idx <= slot_idx + SLOT_IW'(1);
              end
            end
            if ((state == DRAIN) && !mem_wr_o) begin
              state                <= DONE;
              pixel_trigger_done_o <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!pixel_trigger_i) begin
            state                <= IDLE;
            pixel_trigger_done_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_PACK_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || abort || ((state == IDLE) && pixel_trigger_i)) begin
      line_chksum_o <= '0;
    end else if (xfer) begin
      line_chksum_o <= line_chksum_o ^ mem_data_o;
    end
  end
`endif

endmodule
